// File: rtl/voice_allocator.sv
// Allocates the 12 chromatic keys to NVOICE oscillator voices. Key edges are queued as
// pending press/release events and one event is serviced per clock, releases first.
module voice_allocator #(
  parameter int unsigned NVOICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           keys,
  output logic [4*NVOICE-1:0]   voice_note,
  output logic [NVOICE-1:0]     voice_gate,
  output logic [NVOICE-1:0]     voice_new,
  output logic                  busy
);

  localparam int unsigned NKEY = 12;
  localparam int unsigned RW   = $clog2(NVOICE);

  logic [NKEY-1:0]   keys_q, pend_press_q, pend_press_d, pend_rel_q, pend_rel_d;
  logic [NKEY-1:0]   press_e, rel_e;
  logic [3:0]        note_q [NVOICE];
  logic [3:0]        note_d [NVOICE];
  logic [RW-1:0]     rank_q [NVOICE];
  logic [RW-1:0]     rank_d [NVOICE];
  logic [NVOICE-1:0] gate_q, gate_d, new_q, new_d;

  logic [3:0]    rel_k, press_k;
  logic          dup, free_hit;
  logic [RW-1:0] free_v, old_v, tgt, tgt_rank;

  always_comb begin
    press_e = keys & ~keys_q;
    rel_e   = ~keys & keys_q;

    // Descending scans so the lowest set index wins.
    rel_k   = '0;
    press_k = '0;
    for (int k = NKEY - 1; k >= 0; k--) begin
      if (pend_rel_q[k])   rel_k   = 4'(k);
      if (pend_press_q[k]) press_k = 4'(k);
    end

    dup      = 1'b0;
    free_hit = 1'b0;
    free_v   = '0;
    old_v    = '0;
    for (int v = NVOICE - 1; v >= 0; v--) begin
      if (gate_q[v] && note_q[v] == press_k) dup = 1'b1;
      if (!gate_q[v]) begin
        free_hit = 1'b1;
        free_v   = RW'(v);
      end
      if (rank_q[v] == RW'(NVOICE - 1)) old_v = RW'(v);
    end
    tgt      = free_hit ? free_v : old_v;
    tgt_rank = rank_q[tgt];

    pend_press_d = pend_press_q;
    pend_rel_d   = pend_rel_q;
    note_d       = note_q;
    rank_d       = rank_q;
    gate_d       = gate_q;
    new_d        = '0;

    if (|pend_rel_q) begin
      pend_rel_d[rel_k] = 1'b0;
      for (int v = 0; v < NVOICE; v++) begin
        if (gate_q[v] && note_q[v] == rel_k) gate_d[v] = 1'b0;
      end
    end else if (|pend_press_q) begin
      pend_press_d[press_k] = 1'b0;
      if (!dup) begin
        for (int v = 0; v < NVOICE; v++) begin
          if (RW'(v) == tgt) begin
            note_d[v] = press_k;
            gate_d[v] = 1'b1;
            new_d[v]  = 1'b1;
            rank_d[v] = '0;
          end else if (rank_q[v] < tgt_rank) begin
            rank_d[v] = rank_q[v] + RW'(1);
          end
        end
      end
    end

    // New edges are folded in after the service clear; a release cancels an unserviced press.
    for (int k = 0; k < NKEY; k++) begin
      if (press_e[k]) begin
        pend_press_d[k] = 1'b1;
        pend_rel_d[k]   = 1'b0;
      end
      if (rel_e[k]) begin
        if (pend_press_d[k]) pend_press_d[k] = 1'b0;
        else                 pend_rel_d[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_q       <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      gate_q       <= '0;
      new_q        <= '0;
      for (int v = 0; v < NVOICE; v++) begin
        note_q[v] <= '0;
        rank_q[v] <= RW'(v);
      end
    end else begin
      keys_q       <= keys;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      gate_q       <= gate_d;
      new_q        <= new_d;
      note_q       <= note_d;
      rank_q       <= rank_d;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int v = 0; v < NVOICE; v++) voice_note[4*v +: 4] = note_q[v];
  end

  assign voice_gate = gate_q;
  assign voice_new  = new_q;
  assign busy       = |pend_press_q | |pend_rel_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed scenarios plus random key traffic, checked against an LRU-list model of the
// allocator.
module tb_voice_allocator;

  localparam int NV = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [11:0]     keys = '0;
  logic [4*NV-1:0] voice_note;
  logic [NV-1:0]   voice_gate, voice_new;
  logic            busy;

  voice_allocator #(.NVOICE(NV)) dut (
    .clk        (clk),
    .rst        (rst),
    .keys       (keys),
    .voice_note (voice_note),
    .voice_gate (voice_gate),
    .voice_new  (voice_new),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: voices plus an age list (front = most recently assigned).
  int        m_note [NV];
  bit        m_gate [NV];
  bit [NV-1:0] m_new;
  int        age [$];
  bit [11:0] m_pp, m_pr, m_kq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int lowest(input bit [11:0] x);
    for (int k = 0; k < 12; k++) if (x[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_pp = '0; m_pr = '0; m_kq = '0; m_new = '0;
    age.delete();
    for (int v = 0; v < NV; v++) begin
      m_note[v] = 0;
      m_gate[v] = 0;
      age.push_back(v);
    end
  endtask

  task automatic model_edge(input bit [11:0] k_in);
    bit [11:0] pe, re;
    int k, t;
    bit dup;
    pe = k_in & ~m_kq;
    re = ~k_in & m_kq;
    m_new = '0;
    if (m_pr != 0) begin
      k = lowest(m_pr);
      m_pr[k] = 1'b0;
      for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == k) m_gate[v] = 0;
    end else if (m_pp != 0) begin
      k = lowest(m_pp);
      m_pp[k] = 1'b0;
      dup = 0;
      for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == k) dup = 1;
      if (!dup) begin
        t = -1;
        for (int v = 0; v < NV; v++) if (!m_gate[v] && t < 0) t = v;
        if (t < 0) t = age[age.size() - 1];
        for (int i = 0; i < age.size(); i++) if (age[i] == t) begin age.delete(i); break; end
        age.push_front(t);
        m_note[t] = k;
        m_gate[t] = 1;
        m_new[t]  = 1'b1;
      end
    end
    for (int j = 0; j < 12; j++) begin
      if (pe[j]) begin m_pp[j] = 1'b1; m_pr[j] = 1'b0; end
      if (re[j]) begin
        if (m_pp[j]) m_pp[j] = 1'b0;
        else         m_pr[j] = 1'b1;
      end
    end
    m_kq = k_in;
  endtask

  task automatic check_all(input string tag);
    logic [4*NV-1:0] en;
    logic [NV-1:0]   eg;
    for (int v = 0; v < NV; v++) begin
      en[4*v +: 4] = 4'(m_note[v]);
      eg[v]        = m_gate[v];
    end
    chk({tag, "_note"}, 32'(voice_note), 32'(en));
    chk({tag, "_gate"}, 32'(voice_gate), 32'(eg));
    chk({tag, "_new"},  32'(voice_new),  32'(m_new));
    chk({tag, "_busy"}, 32'(busy),       32'(m_pp != 0 || m_pr != 0));
  endtask

  task automatic step(input logic [11:0] k, input string tag);
    keys = k;
    @(posedge clk);
    model_edge(k);
    #1;
    check_all(tag);
  endtask

  // Hold keys until the model queue drains, then one extra cycle.
  task automatic settle(input logic [11:0] k, input string tag);
    int n = 0;
    step(k, tag);
    while ((m_pp != 0 || m_pr != 0) && n < 30) begin
      step(k, tag);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 30), 32'd1);
    step(k, tag);
  endtask

  initial begin
    bit [11:0] rk;
    model_reset();
    #2;
    chk("rst_note", 32'(voice_note), 32'd0);
    chk("rst_gate", 32'(voice_gate), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(12'h000, "idle");

    // Single note
    step(12'h001, "single_e0");
    chk("single_busy_e0", 32'(busy), 32'd1);
    step(12'h001, "single_e1");
    chk("single_new_e1", 32'(voice_new), 32'h1);
    chk("single_gate_e1", 32'(voice_gate), 32'h1);
    step(12'h001, "single_e2");
    chk("single_new_e2", 32'(voice_new), 32'h0);
    step(12'h001, "single_e3");
    step(12'h001, "single_e4");
    step(12'h000, "single_e5");
    step(12'h000, "single_e6");
    chk("single_off", 32'(voice_gate), 32'h0);

    // Chord 2,4,7
    step(12'h094, "chord_e0");
    step(12'h094, "chord_e1");
    step(12'h094, "chord_e2");
    chk("chord_busy_e2", 32'(busy), 32'd1);
    step(12'h094, "chord_e3");
    chk("chord_notes", 32'(voice_note), 32'h0742);
    chk("chord_busy_e3", 32'(busy), 32'd0);
    settle(12'h000, "chord_rel");

    // Steal: fill voices with keys 0..3, then 9 and 10 steal the two oldest
    step(12'h001, "steal_a");
    step(12'h003, "steal_b");
    step(12'h007, "steal_c");
    step(12'h00F, "steal_d");
    step(12'h20F, "steal_e");
    step(12'h20F, "steal_9");
    chk("steal9_new", 32'(voice_new), 32'h1);
    chk("steal9_note", 32'(voice_note), 32'h3219);
    step(12'h60F, "steal_f");
    step(12'h60F, "steal_10");
    chk("steal10_new", 32'(voice_new), 32'h2);
    chk("steal10_note", 32'(voice_note), 32'h32A9);
    settle(12'h000, "steal_rel");

    // Priority: hold 5, then press 3 while releasing 5
    settle(12'h020, "prio_hold");
    step(12'h008, "prio_e0");
    step(12'h008, "prio_rel5");
    chk("prio_rel5_new", 32'(voice_new), 32'h0);
    step(12'h008, "prio_press3");
    chk("prio_press3_new", 32'(voice_new) != 0 ? 32'd1 : 32'd0, 32'd1);
    settle(12'h000, "prio_rel");

    // Bounce: key 8 pulse queued behind presses 0,1,2 is cancelled
    step(12'h107, "bounce_a");
    settle(12'h007, "bounce_b");
    settle(12'h000, "bounce_rel");

    // Duplicate: release 1 and 4 together, re-press 4 before its release is serviced
    settle(12'h012, "dup_hold");
    step(12'h000, "dup_rel");
    step(12'h010, "dup_repress");
    step(12'h010, "dup_svc");
    chk("dup_new", 32'(voice_new), 32'h0);
    settle(12'h010, "dup_settle");
    settle(12'h000, "dup_rel2");

    // Reset mid-run with three voices gated and events pending
    settle(12'h007, "mrst_fill");
    step(12'h0F7, "mrst_pend");
    rst = 1'b1;
    #1;
    model_reset();
    chk("mrst_note", 32'(voice_note), 32'd0);
    chk("mrst_gate", 32'(voice_gate), 32'd0);
    chk("mrst_new", 32'(voice_new), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    keys = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(12'h000, "mrst_exit");
    step(12'h000, "mrst_exit2");

    // Random key traffic
    rk = '0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: ;
        1: rk[$urandom_range(0, 11)] ^= 1'b1;
        2: begin
          rk[$urandom_range(0, 11)] ^= 1'b1;
          rk[$urandom_range(0, 11)] ^= 1'b1;
        end
        default: rk = 12'($urandom);
      endcase
      step(rk, "rand");
    end
    settle(12'h000, "rand_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
